edge_detect_multi: RTL and testbench

- Parametrised multi-channel edge detector for WIDTH independent input bits.
- Per-channel glitch filter; runtime-selectable edge mode (rise/fall/any/off); single-cycle edge pulses; sticky pending flags with write-1-to-clear; saturating event counter; interrupt output.
- Sits between raw status/GPIO inputs and the control logic or interrupt logic that consumes edge events.

---
 rtl/edge_detect_multi.sv | 225 ++++++++++++++++++++++
 tb/tb_edge_detect_multi.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// -----------------------------------------------------------------------------
// edge_detect_multi
//
// Multi-channel edge detector. Each of WIDTH independent input bits is
// sampled, glitch-filtered, and checked for edges. A rising, falling or
// either-direction edge, chosen at runtime by mode, qualifies on the clock
// where the filter accepts a new level. Each qualified edge produces:
//   - a one-cycle pulse,
//   - a sticky pending flag that is cleared by writing 1 to clr,
//   - one count in a saturating event counter (one count per clock,
//     however many channels fire on that clock),
//   - an interrupt, which is the OR of the pending flags.
//
// Parameters:
//   WIDTH       number of input channels
//   FILT_CYCLES consecutive samples a new level must persist (1..255, 1 = off)
//   CNT_W       width of evt_count
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   in          raw channel inputs
//   mode        00 off, 01 rising, 10 falling, 11 any
//   clr         write-1-to-clear for pending, one bit per channel
//   cnt_clr     synchronous clear of evt_count
//   edge_pulse  one-cycle pulse per qualified edge
//   pending     sticky qualified-edge flags
//   evt_count   saturating count of clocks with at least one qualified edge
//   irq         OR of pending, registered together with pending
//
// Optional build macro EDGE_SYNC_EN:
//   When defined, a 2-flop synchroniser sits ahead of the sample register,
//   so in may be asynchronous to clk. Every latency grows by 2 clocks.
//   When undefined, in must be synchronous to clk.
// -----------------------------------------------------------------------------
`default_nettype none

module edge_detect_multi #(
  parameter int WIDTH       = 8,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] clr,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] edge_pulse,
  output logic [WIDTH-1:0] pending,
  output logic [CNT_W-1:0] evt_count,
  output logic             irq
);

  // Filter counter width: ceil(log2(FILT_CYCLES)), never narrower than 1 bit.
  localparam int FCW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  localparam logic [FCW-1:0]   FILT_LAST = FCW'(FILT_CYCLES - 1);
  localparam logic [FCW-1:0]   FCNT_ONE  = FCW'(1);
  localparam logic [CNT_W-1:0] EVT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] EVT_MAX   = '1;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_ANY  = 2'b11;

  // Source feeding the sample register
  logic [WIDTH-1:0] samp_src;

`ifdef EDGE_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  // Two-flop synchroniser ahead of the sample register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  assign samp_src = sync2_q;
`else
  assign samp_src = in;
`endif

  // State registers and their next-state values
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [FCW-1:0]   fcnt_q [WIDTH];
  logic [FCW-1:0]   fcnt_d [WIDTH];
  logic [WIDTH-1:0] pulse_q;
  logic [WIDTH-1:0] pend_q;
  logic [WIDTH-1:0] pend_d;
  logic             irq_q;
  logic             irq_d;
  logic [CNT_W-1:0] evt_q;
  logic [CNT_W-1:0] evt_d;

  // Per-clock decision signals
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] qual;
  logic             any_qual;

  // ---------------------------------------------------------------------------
  // Glitch filter.
  // A channel accepts a new level on the FILT_CYCLES-th consecutive sample
  // that differs from its filtered level. Any sample that agrees with the
  // filtered level restarts the count, so a short glitch never gets through.
  // ---------------------------------------------------------------------------
  always_comb begin
    stable_d = stable_q;
    accept   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fcnt_d[i] = fcnt_q[i];
      if (s_q[i] != stable_q[i]) begin
        if (fcnt_q[i] == FILT_LAST) begin
          stable_d[i] = s_q[i];
          fcnt_d[i]   = '0;
          accept[i]   = 1'b1;
        end else begin
          fcnt_d[i] = fcnt_q[i] + FCNT_ONE;
        end
      end else begin
        fcnt_d[i] = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Edge qualification.
  // On an accept, the newly accepted level gives the edge direction:
  // a sample of 1 is a rising edge and a sample of 0 is a falling edge.
  // mode is used exactly as it stands on the accepting clock. In mode 00
  // the filter still tracks the input, so enabling detection later does
  // not report a stale edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    qual = '0;
    case (mode)
      MODE_RISE: qual = accept & s_q;
      MODE_FALL: qual = accept & ~s_q;
      MODE_ANY:  qual = accept;
      MODE_OFF:  qual = '0;
      default:   qual = '0;
    endcase
  end

  assign any_qual = |qual;

  // ---------------------------------------------------------------------------
  // Pending flags and interrupt.
  // A new edge overrides a clear landing on the same clock, so no event
  // is lost. irq is built from the next pending value, so it moves on the
  // same clock as pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_d = (pend_q & ~clr) | qual;
    irq_d  = |pend_d;
  end

  // ---------------------------------------------------------------------------
  // Event counter.
  // Adds one per clock that has any qualified edge and stops at all-ones.
  // When cnt_clr and an event land on the same clock, that event is
  // counted, so the counter loads 1 instead of 0.
  // ---------------------------------------------------------------------------
  always_comb begin
    evt_d = evt_q;
    if (cnt_clr) begin
      evt_d = any_qual ? EVT_ONE : '0;
    end else if (any_qual && (evt_q != EVT_MAX)) begin
      evt_d = evt_q + EVT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample register and filter state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= '0;
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        fcnt_q[i] <= '0;
      end
    end else begin
      s_q      <= samp_src;
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        fcnt_q[i] <= fcnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      evt_q   <= '0;
    end else begin
      pulse_q <= qual;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      evt_q   <= evt_d;
    end
  end

  assign edge_pulse = pulse_q;
  assign pending    = pend_q;
  assign irq        = irq_q;
  assign evt_count  = evt_q;

endmodule

`default_nettype wire

// File: tb/tb_edge_detect_multi.sv
`timescale 1ns/1ps

module tb_edge_detect_multi;

  localparam int WIDTH = 8;
  localparam int FILT  = 4;
  localparam int CNT_W = 4;
`ifdef EDGE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_r;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] clr_r;
  logic             cnt_clr_r;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] pending;
  logic [CNT_W-1:0] evt_count;
  logic             irq;

  edge_detect_multi #(
    .WIDTH      (WIDTH),
    .FILT_CYCLES(FILT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_r),
    .mode      (mode_r),
    .clr       (clr_r),
    .cnt_clr   (cnt_clr_r),
    .edge_pulse(edge_pulse),
    .pending   (pending),
    .evt_count (evt_count),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model. Each channel keeps a window of its last FILT samples.
  // A channel accepts level v when the whole window equals v and its
  // filtered level is not v.
  logic [WIDTH-1:0] m_s, m_y1, m_y2, m_stable, m_pulse, m_pend;
  logic             m_irq;
  logic [CNT_W-1:0] m_cnt;
  logic [FILT-1:0]  m_hist [WIDTH];

  task automatic model_reset();
    m_s = '0; m_y1 = '0; m_y2 = '0; m_stable = '0;
    m_pulse = '0; m_pend = '0; m_irq = 1'b0; m_cnt = '0;
    for (int i = 0; i < WIDTH; i++) m_hist[i] = '0;
  endtask

  task automatic model_clock();
    logic [WIDTH-1:0] s_old;
    logic [WIDTH-1:0] qual;
    s_old = m_s;
`ifdef EDGE_SYNC_EN
    m_s  = m_y2;
    m_y2 = m_y1;
    m_y1 = in_r;
`else
    m_s = in_r;
`endif
    qual = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m_hist[i] = FILT'({m_hist[i], s_old[i]});
      if ((m_hist[i] == {FILT{s_old[i]}}) && (m_stable[i] != s_old[i])) begin
        m_stable[i] = s_old[i];
        case (mode_r)
          2'b01:   qual[i] = s_old[i];
          2'b10:   qual[i] = ~s_old[i];
          2'b11:   qual[i] = 1'b1;
          default: qual[i] = 1'b0;
        endcase
      end
    end
    m_pulse = qual;
    m_pend  = (m_pend & ~clr_r) | qual;
    m_irq   = |m_pend;
    if (cnt_clr_r)
      m_cnt = {{(CNT_W-1){1'b0}}, |qual};
    else if ((|qual) && (m_cnt != CMAX))
      m_cnt = m_cnt + CNT_W'(1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_clock();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_r = '0; clr_r = '0; cnt_clr_r = 1'b0; mode_r = 2'b01;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Hold the current inputs and expect exactly one pulse after the filter time.
  task automatic wait_edge(input string nm, input logic [WIDTH-1:0] exp_pulse,
                           input logic [WIDTH-1:0] clr_e, input logic cc_e);
    logic early;
    early = 1'b0;
    for (int k = 0; k < LAT + FILT; k++) begin
      step();
      if (edge_pulse != '0) early = 1'b1;
    end
    check({nm, "_early"}, 32'(early), 32'(0));
    clr_r = clr_e;
    cnt_clr_r = cc_e;
    step();
    check({nm, "_pulse"}, 32'(edge_pulse), 32'(exp_pulse));
    clr_r = '0;
    cnt_clr_r = 1'b0;
  endtask

  typedef struct {
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] pulse;
    logic [WIDTH-1:0] pend;
    logic             irq;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add_rows(input int n, input logic [WIDTH-1:0] i, input logic [WIDTH-1:0] p,
                          input logic [WIDTH-1:0] pd, input logic q, input logic [CNT_W-1:0] c);
    vec_t v;
    v.in = i; v.pulse = p; v.pend = pd; v.irq = q; v.cnt = c;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    rst = 1'b1; in_r = '0; mode_r = 2'b01; clr_r = '0; cnt_clr_r = 1'b0;
    model_reset();

    // Rising edge on bit 0, a 3-sample glitch on bit 3 that must be
    // filtered out, a real 4-sample rise on bit 3, then a falling edge on
    // bit 3 that rising mode ignores.
    add_rows(4, 8'h01, 8'h00, 8'h00, 1'b0, 4'd0);
    add_rows(1, 8'h01, 8'h01, 8'h01, 1'b1, 4'd1);
    add_rows(2, 8'h01, 8'h00, 8'h01, 1'b1, 4'd1);
    add_rows(3, 8'h09, 8'h00, 8'h01, 1'b1, 4'd1);
    add_rows(3, 8'h01, 8'h00, 8'h01, 1'b1, 4'd1);
    add_rows(4, 8'h09, 8'h00, 8'h01, 1'b1, 4'd1);
    add_rows(1, 8'h09, 8'h08, 8'h09, 1'b1, 4'd2);
    add_rows(1, 8'h09, 8'h00, 8'h09, 1'b1, 4'd2);
    add_rows(5, 8'h01, 8'h00, 8'h09, 1'b1, 4'd2);

    do_reset();
    check("reset", 32'({edge_pulse, pending, irq, evt_count}), 32'(0));

    // Table: outputs trail the table rows by the synchroniser latency
    for (int t = 0; t < tbl.size() + LAT; t++) begin
      in_r = tbl[(t < tbl.size()) ? t : tbl.size() - 1].in;
      step();
      if (t >= LAT)
        check($sformatf("tbl%0d", t - LAT), 32'({edge_pulse, pending, irq, evt_count}),
              32'({tbl[t-LAT].pulse, tbl[t-LAT].pend, tbl[t-LAT].irq, tbl[t-LAT].cnt}));
      else
        check($sformatf("tbl_pre%0d", t), 32'({edge_pulse, pending, irq, evt_count}), 32'(0));
    end

    // Two channels rising together: one pulse cycle, one count
    do_reset();
    mode_r = 2'b11;
    in_r = 8'h06;
    wait_edge("t3_rise", 8'h06, '0, 1'b0);
    check("t3_cnt1", 32'(evt_count), 32'(1));
    check("t3_pend", 32'(pending), 32'(8'h06));
    step();
    check("t3_single", 32'(edge_pulse), 32'(0));
    in_r = 8'h00;
    wait_edge("t3_fall", 8'h06, '0, 1'b0);
    check("t3_cnt2", 32'(evt_count), 32'(2));

    // A new edge wins over a clear on the same clock
    do_reset();
    mode_r = 2'b11;
    in_r = 8'h20;
    wait_edge("t4_set", 8'h20, '0, 1'b0);
    check("t4_pend", 32'(pending), 32'(8'h20));
    mode_r = 2'b10;
    in_r = 8'h00;
    wait_edge("t4_fall", 8'h20, 8'h20, 1'b0);
    check("t4_setwins", 32'({pending, irq}), 32'({8'h20, 1'b1}));
    clr_r = 8'h20;
    step();
    clr_r = '0;
    check("t4_clear", 32'({pending, irq}), 32'(0));

    // Counter saturation and cnt_clr behaviour
    do_reset();
    mode_r = 2'b11;
    for (int k = 0; k < 20; k++) begin
      in_r = in_r ^ 8'h01;
      wait_edge($sformatf("t5_evt%0d", k), 8'h01, '0, 1'b0);
    end
    check("t5_sat", 32'(evt_count), 32'(15));
    in_r = in_r ^ 8'h01;
    wait_edge("t5_ccev", 8'h01, '0, 1'b1);
    check("t5_cc_ev", 32'(evt_count), 32'(1));
    cnt_clr_r = 1'b1;
    step();
    cnt_clr_r = 1'b0;
    check("t5_cc_only", 32'(evt_count), 32'(0));

    // Asynchronous reset in the middle of a filter run
    do_reset();
    mode_r = 2'b01;
    in_r = 8'h02;
    wait_edge("t6_pre", 8'h02, '0, 1'b0);
    in_r = 8'h03;
    for (int k = 0; k < LAT + 3; k++) step();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_async", 32'({edge_pulse, pending, irq, evt_count}), 32'(0));
    @(posedge clk);
    #1;
    check("t6_hold", 32'({edge_pulse, pending, irq, evt_count}), 32'(0));
    rst = 1'b0;
    wait_edge("t6_release", 8'h03, '0, 1'b0);
    check("t6_pend", 32'({pending, irq, evt_count}), 32'({8'h03, 1'b1, 4'd1}));

    // Randomised run against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [WIDTH-1:0] flip;
      flip = '0;
      for (int i = 0; i < WIDTH; i++)
        if ($urandom_range(9) == 0) flip[i] = 1'b1;
      in_r = in_r ^ flip;
      if ($urandom_range(49) == 0) mode_r = 2'($urandom_range(3));
      clr_r = WIDTH'($urandom & $urandom & $urandom);
      cnt_clr_r = ($urandom_range(39) == 0);
      step();
      check($sformatf("rand%0d", c), 32'({edge_pulse, pending, irq, evt_count}),
            32'({m_pulse, m_pend, m_irq, m_cnt}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
